// File: rtl/servo_pkg.sv
// Shared servo definitions: angle type, ramp FSM states and the system clock rate
// used by both the ramp limiter and the PWM stage.
package servo_pkg;

    localparam int ANGLE_W       = 8;
    localparam int ANGLE_MAX_DEG = 180;
    localparam int CLK_HZ        = 50_000_000;

    typedef logic [ANGLE_W-1:0] angle_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAMP   = 2'd1,
        SETTLE = 2'd2
    } ramp_state_e;

    // Tick counter width: enough bits to hold the larger of the two interval limits.
    function automatic int cnt_width(input int step_ticks, input int settle_ticks);
        int m;
        int w;
        m = (step_ticks > settle_ticks) ? step_ticks : settle_ticks;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/servo_angle_ramp_if.sv
// Target-command handshake plus the angle/status outputs of the servo ramp limiter.
// master drives targets and hold; slave is the ramp limiter itself.
interface servo_angle_ramp_if;
    import servo_pkg::*;

    angle_t target_angle;
    logic   target_valid;
    logic   target_ready;
    logic   hold;
    angle_t angle;
    logic   busy;
    logic   at_target;
    logic   clamped;

    modport master (
        output target_angle, target_valid, hold,
        input  target_ready, angle, busy, at_target, clamped
    );

    modport slave (
        input  target_angle, target_valid, hold,
        output target_ready, angle, busy, at_target, clamped
    );

endinterface

// File: rtl/ramp_tick_counter.sv
// Clearable tick counter with enable; wraps to zero on the cycle it reaches the
// runtime terminal value 'last' and flags that cycle combinationally.
module ramp_tick_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             en,
    input  logic [CNT_W-1:0] last,
    output logic             terminal
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    assign terminal = (count_reg == last);

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (en) begin
            count_next = terminal ? '0 : count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/servo_angle_ramp.sv
// Slew-rate limiter ahead of the servo PWM stage: steps the angle 1 degree per
// STEP_TICKS toward the accepted target, then settles. Optional lower clamp: SERVO_SOFT_LIMIT_EN.
module servo_angle_ramp
    import servo_pkg::*;
#(
    parameter int STEP_TICKS   = 500_000,
    parameter int SETTLE_TICKS = 1_000_000,
    parameter int HOME_ANGLE   = 90,
    parameter int MAX_ANGLE    = ANGLE_MAX_DEG
`ifdef SERVO_SOFT_LIMIT_EN
    ,
    parameter int MIN_ANGLE    = 0
`endif
) (
    input  logic               clk,
    input  logic               reset_n,
    servo_angle_ramp_if.slave  bus
);

    localparam int               CNT_W       = cnt_width(STEP_TICKS, SETTLE_TICKS);
    localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP_TICKS - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_TICKS - 1);
    localparam angle_t           MAX_A       = angle_t'(MAX_ANGLE);

`ifdef SERVO_SOFT_LIMIT_EN
    localparam angle_t MIN_A    = angle_t'(MIN_ANGLE);
    localparam int     HOME_FIT = (HOME_ANGLE < MIN_ANGLE) ? MIN_ANGLE :
                                  (HOME_ANGLE > MAX_ANGLE) ? MAX_ANGLE : HOME_ANGLE;
    localparam angle_t HOME_RST = angle_t'(HOME_FIT);

    generate
        if (MIN_ANGLE > MAX_ANGLE) begin : g_bad_limits
            $error("servo_angle_ramp: MIN_ANGLE exceeds MAX_ANGLE");
        end
        if (HOME_ANGLE != HOME_FIT) begin : g_home_forced
            $warning("servo_angle_ramp: HOME_ANGLE outside soft limits, forced into range");
        end
    endgenerate
`else
    localparam angle_t HOME_RST = angle_t'(HOME_ANGLE);
`endif

    ramp_state_e state_reg, state_next;
    angle_t      angle_reg, angle_next;
    angle_t      tgt_reg, tgt_next;
    logic        clamped_reg, clamped_next;
    logic        ready_reg, busy_reg, at_target_reg;

    angle_t           tgt_clamped;
    logic             clamp_hit;
    angle_t           angle_step;
    logic             accept;
    logic             cnt_clear, cnt_en, cnt_terminal;
    logic [CNT_W-1:0] cnt_last;

    assign accept     = bus.target_valid && ready_reg;
    assign angle_step = (angle_reg < tgt_reg) ? angle_reg + 8'd1 : angle_reg - 8'd1;
    assign cnt_last   = (state_reg == SETTLE) ? SETTLE_LAST : STEP_LAST;

    always_comb begin
        tgt_clamped = bus.target_angle;
        clamp_hit   = 1'b0;
        if (bus.target_angle > MAX_A) begin
            tgt_clamped = MAX_A;
            clamp_hit   = 1'b1;
        end
`ifdef SERVO_SOFT_LIMIT_EN
        else if (bus.target_angle < MIN_A) begin
            tgt_clamped = MIN_A;
            clamp_hit   = 1'b1;
        end
`endif
    end

    ramp_tick_counter #(
        .CNT_W (CNT_W)
    ) u_tick (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (cnt_clear),
        .en       (cnt_en),
        .last     (cnt_last),
        .terminal (cnt_terminal)
    );

    always_comb begin
        state_next   = state_reg;
        angle_next   = angle_reg;
        tgt_next     = tgt_reg;
        clamped_next = 1'b0;
        cnt_clear    = 1'b0;
        cnt_en       = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    tgt_next     = tgt_clamped;
                    clamped_next = clamp_hit;
                    if (tgt_clamped != angle_reg) begin
                        state_next = RAMP;
                        cnt_clear  = 1'b1;
                    end
                end
            end
            RAMP: begin
                if (!bus.hold) begin
                    cnt_en = 1'b1;
                    // Counter wraps on the step edge, so SETTLE starts from zero.
                    if (cnt_terminal) begin
                        angle_next = angle_step;
                        if (angle_step == tgt_reg) begin
                            state_next = SETTLE;
                        end
                    end
                end
            end
            SETTLE: begin
                if (!bus.hold) begin
                    cnt_en = 1'b1;
                    if (cnt_terminal) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            angle_reg     <= HOME_RST;
            tgt_reg       <= HOME_RST;
            clamped_reg   <= 1'b0;
            ready_reg     <= 1'b1;
            busy_reg      <= 1'b0;
            at_target_reg <= 1'b1;
        end else begin
            state_reg     <= state_next;
            angle_reg     <= angle_next;
            tgt_reg       <= tgt_next;
            clamped_reg   <= clamped_next;
            ready_reg     <= (state_next == IDLE);
            busy_reg      <= (state_next != IDLE);
            at_target_reg <= (state_next == IDLE);
        end
    end

    assign bus.target_ready = ready_reg;
    assign bus.angle        = angle_reg;
    assign bus.busy         = busy_reg;
    assign bus.at_target    = at_target_reg;
    assign bus.clamped      = clamped_reg;

endmodule
